muldiv_iter: RTL and testbench

Multi-cycle RISC-V M-extension execute unit: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU plus RV64 word forms (MULW/DIVW/DIVUW/REMW/REMUW).
- Parametrised in XLEN.
- Valid/ready handshake on both sides.
- Architecturally correct divide-by-zero and signed-overflow results.
- Sits beside the single-cycle integer ALU in EX; the pipeline stalls on in_ready/out_valid.
- Replaces the combinational `*`, `/` and `%` path so the block closes timing.

---
 rtl/muldiv_pkg.sv | 46 ++++
 rtl/muldiv_div_step.sv | 30 +++
 rtl/muldiv_iter.sv | 250 +++++++++++++++++++++++++
 tb/tb_muldiv_iter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: funct3 opcodes,
// FSM states and the one-hot debug view of the accepted instruction.
package muldiv_pkg;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    localparam logic [7:0] DEBUG_INST_MUL    = 8'h80;
    localparam logic [7:0] DEBUG_INST_MULH   = 8'h40;
    localparam logic [7:0] DEBUG_INST_MULHSU = 8'h20;
    localparam logic [7:0] DEBUG_INST_MULHU  = 8'h10;
    localparam logic [7:0] DEBUG_INST_DIV    = 8'h08;
    localparam logic [7:0] DEBUG_INST_DIVU   = 8'h04;
    localparam logic [7:0] DEBUG_INST_REM    = 8'h02;
    localparam logic [7:0] DEBUG_INST_REMU   = 8'h01;
    localparam logic [7:0] DEBUG_INST_NONE   = 8'h00;

    function automatic logic [7:0] debug_onehot(input logic [2:0] f3);
        logic [7:0] oh;
        case (f3)
            MD_MUL:    oh = DEBUG_INST_MUL;
            MD_MULH:   oh = DEBUG_INST_MULH;
            MD_MULHSU: oh = DEBUG_INST_MULHSU;
            MD_MULHU:  oh = DEBUG_INST_MULHU;
            MD_DIV:    oh = DEBUG_INST_DIV;
            MD_DIVU:   oh = DEBUG_INST_DIVU;
            MD_REM:    oh = DEBUG_INST_REM;
            MD_REMU:   oh = DEBUG_INST_REMU;
            default:   oh = DEBUG_INST_NONE;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module muldiv_div_step
    import muldiv_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic            dvd_bit_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic            q_bit_o
);

    logic [XLEN:0] shifted_s;
    logic [XLEN:0] diff_s;

    // rem_i < divisor_i keeps the shifted value below divisor + 2^XLEN, so the top diff bit is a clean borrow
    always_comb begin
        shifted_s = {rem_i, dvd_bit_i};
        diff_s    = shifted_s - {1'b0, divisor_i};
        q_bit_o   = ~diff_s[XLEN];
        if (q_bit_o) begin
            rem_o = diff_s[XLEN-1:0];
        end else begin
            rem_o = shifted_s[XLEN-1:0];
        end
    end

endmodule

// File: rtl/muldiv_iter.sv
// Multi-cycle RISC-V M-extension execute unit (MUL*/DIV*/REM* and RV64 *W forms).
// Define MULDIV_FAST_MUL_EN to complete multiplies in a single combinational step.
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic            word,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy,
    output logic [7:0]      debug_inst
);

    localparam int CW = 7;
    localparam logic [CW-1:0] LAST_FULL = CW'(XLEN - 1);
    localparam logic [CW-1:0] LAST_WORD = 7'd31;
    localparam logic [XLEN-1:0] ZERO = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ONES = {XLEN{1'b1}};

    md_state_e       state_q, state_d;
    logic [2:0]      f3_q, f3_d;
    logic            word_q, word_d;
    logic            neg_q, neg_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            out_valid_q, out_valid_d;
    logic [7:0]      debug_q, debug_d;

    logic            word_s, signed_a_s, signed_b_s, sa_s, sb_s, neg_s;
    logic [XLEN-1:0] a_ext_s, b_ext_s, mag_a_s, mag_b_s, div_init_s, min_neg_s;
    logic            illegal_s, div0_s, ovf_s, special_s;
    logic [XLEN-1:0] special_res_s;
    logic [XLEN:0]   mul_sum_s;
    logic [XLEN-1:0] step_rem_s, iter_acc_s, iter_a_s, div_val_s, raw_res_s, fin_res_s;
    logic            step_q_s, last_s;
    logic [2*XLEN-1:0] prod_s, prod_signed_s;

    function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
        return XLEN'($signed(v[31:0]));
    endfunction

    function automatic logic [XLEN-1:0] word_fix(input logic [XLEN-1:0] v, input logic w);
        return w ? sext32(v) : v;
    endfunction

    function automatic logic [XLEN-1:0] mul_sel(input logic [2*XLEN-1:0] p, input logic [2:0] f3);
        return (f3 == MD_MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    endfunction

    // Operand conditioning and special-case detection on the incoming request
    always_comb begin
        word_s     = (XLEN == 64) ? word : 1'b0;
        signed_a_s = (funct3 == MD_MUL) || (funct3 == MD_MULH) || (funct3 == MD_MULHSU) ||
                     (funct3 == MD_DIV) || (funct3 == MD_REM);
        signed_b_s = (funct3 == MD_MUL) || (funct3 == MD_MULH) ||
                     (funct3 == MD_DIV) || (funct3 == MD_REM);
        if (word_s) begin
            a_ext_s = signed_a_s ? sext32(op_a) : XLEN'(op_a[31:0]);
            b_ext_s = signed_b_s ? sext32(op_b) : XLEN'(op_b[31:0]);
        end else begin
            a_ext_s = op_a;
            b_ext_s = op_b;
        end
        sa_s       = signed_a_s & a_ext_s[XLEN-1];
        sb_s       = signed_b_s & b_ext_s[XLEN-1];
        mag_a_s    = sa_s ? -a_ext_s : a_ext_s;
        mag_b_s    = sb_s ? -b_ext_s : b_ext_s;
        // remainder follows the dividend; everything else follows sign(a) ^ sign(b)
        neg_s      = (funct3[2] && funct3[1]) ? sa_s : (sa_s ^ sb_s);
        div_init_s = word_s ? (mag_a_s << 7'd32) : mag_a_s;
        min_neg_s  = word_s ? sext32(XLEN'(32'h8000_0000)) : {1'b1, {(XLEN-1){1'b0}}};
        illegal_s  = word_s && !funct3[2] && (funct3[1:0] != 2'b00);
        div0_s     = funct3[2] && (b_ext_s == ZERO);
        ovf_s      = funct3[2] && !funct3[0] && (a_ext_s == min_neg_s) && (b_ext_s == ONES);
        special_s  = illegal_s || div0_s || ovf_s;
        if (illegal_s) begin
            special_res_s = ZERO;
        end else if (div0_s) begin
            special_res_s = word_fix(funct3[1] ? a_ext_s : ONES, word_s);
        end else if (ovf_s) begin
            special_res_s = word_fix(funct3[1] ? ZERO : a_ext_s, word_s);
        end else begin
            special_res_s = ZERO;
        end
    end

    muldiv_div_step #(.XLEN(XLEN)) u_div_step (
        .rem_i     (acc_q),
        .dvd_bit_i (a_q[XLEN-1]),
        .divisor_i (b_q),
        .rem_o     (step_rem_s),
        .q_bit_o   (step_q_s)
    );

    // One iteration of shift-add multiply or restoring divide, plus final sign/width fix-up
    always_comb begin
        mul_sum_s = {1'b0, acc_q} + {1'b0, (a_q[0] ? b_q : ZERO)};
        if (f3_q[2]) begin
            iter_acc_s = step_rem_s;
            iter_a_s   = {a_q[XLEN-2:0], step_q_s};
        end else begin
            iter_acc_s = mul_sum_s[XLEN:1];
            iter_a_s   = {mul_sum_s[0], a_q[XLEN-1:1]};
        end
        // after N of XLEN right shifts the word-mode product still sits 32 bits high
        prod_s        = word_q ? ({iter_acc_s, iter_a_s} >> 7'd32) : {iter_acc_s, iter_a_s};
        prod_signed_s = neg_q ? -prod_s : prod_s;
        div_val_s     = f3_q[1] ? iter_acc_s : iter_a_s;
        if (f3_q[2]) begin
            raw_res_s = neg_q ? -div_val_s : div_val_s;
        end else begin
            raw_res_s = mul_sel(prod_signed_s, f3_q);
        end
        fin_res_s = word_fix(raw_res_s, word_q);
        last_s    = (cnt_q == (word_q ? LAST_WORD : LAST_FULL));
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod_s;
    logic [XLEN-1:0]   fast_res_s;

    // Single-step multiplier on operand magnitudes
    always_comb begin
        fast_prod_s = (2*XLEN)'(mag_a_s) * (2*XLEN)'(mag_b_s);
        fast_res_s  = word_fix(mul_sel(neg_s ? -fast_prod_s : fast_prod_s, funct3), word_s);
    end
`endif

    // Next-state logic for the IDLE -> CALC -> DONE sequencer
    always_comb begin
        state_d     = state_q;
        f3_d        = f3_q;
        word_d      = word_q;
        neg_d       = neg_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;
        debug_d     = debug_q;
        case (state_q)
            MD_IDLE: begin
                if (in_valid && !flush) begin
                    f3_d    = funct3;
                    word_d  = word_s;
                    neg_d   = neg_s;
                    cnt_d   = {CW{1'b0}};
                    a_d     = funct3[2] ? div_init_s : mag_a_s;
                    b_d     = mag_b_s;
                    acc_d   = ZERO;
                    debug_d = debug_onehot(funct3);
                    if (special_s) begin
                        state_d  = MD_DONE;
                        result_d = special_res_s;
`ifdef MULDIV_FAST_MUL_EN
                    end else if (!funct3[2]) begin
                        state_d  = MD_DONE;
                        result_d = fast_res_s;
`endif
                    end else begin
                        state_d = MD_CALC;
                    end
                end else begin
                    state_d = MD_IDLE;
                end
            end
            MD_CALC: begin
                a_d   = iter_a_s;
                acc_d = iter_acc_s;
                cnt_d = cnt_q + 7'd1;
                if (last_s) begin
                    state_d  = MD_DONE;
                    result_d = fin_res_s;
                end else begin
                    state_d = MD_CALC;
                end
            end
            MD_DONE: begin
                // out_valid trails entry into DONE by one cycle
                if (out_valid_q && out_ready) begin
                    state_d     = MD_IDLE;
                    out_valid_d = 1'b0;
                    debug_d     = DEBUG_INST_NONE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = MD_IDLE;
                out_valid_d = 1'b0;
                debug_d     = DEBUG_INST_NONE;
            end
        endcase
        if (flush) begin
            state_d     = MD_IDLE;
            out_valid_d = 1'b0;
            debug_d     = DEBUG_INST_NONE;
        end else begin
            state_d = state_d;
        end
    end

    // State and datapath registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= MD_IDLE;
            f3_q        <= 3'b000;
            word_q      <= 1'b0;
            neg_q       <= 1'b0;
            cnt_q       <= {CW{1'b0}};
            a_q         <= ZERO;
            b_q         <= ZERO;
            acc_q       <= ZERO;
            result_q    <= ZERO;
            out_valid_q <= 1'b0;
            debug_q     <= DEBUG_INST_NONE;
        end else begin
            state_q     <= state_d;
            f3_q        <= f3_d;
            word_q      <= word_d;
            neg_q       <= neg_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            debug_q     <= debug_d;
        end
    end

    assign in_ready   = (state_q == MD_IDLE);
    assign busy       = (state_q != MD_IDLE);
    assign out_valid  = out_valid_q;
    assign result     = result_q;
    assign debug_inst = debug_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Table-driven self-checking bench for muldiv_iter (XLEN=64) with a result scoreboard.
module tb_muldiv_iter;
    import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
    localparam int LAT_MUL  = 1;
    localparam int LAT_MULW = 1;
`else
    localparam int LAT_MUL  = 65;
    localparam int LAT_MULW = 33;
`endif

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, word, out_valid, out_ready, busy;
    logic [2:0]  funct3;
    logic [63:0] op_a, op_b, result;
    logic [7:0]  debug_inst;

    always #5 clk = ~clk;

    muldiv_iter #(.XLEN(64)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .funct3(funct3), .word(word), .op_a(op_a), .op_b(op_b), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .busy(busy), .debug_inst(debug_inst)
    );

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic        w;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t        vecs[$];
    logic [63:0] sb_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input string nm, input logic [2:0] f3, input logic w,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] e, input int lat);
        vec_t v;
        v.name = nm; v.f3 = f3; v.w = w; v.a = a; v.b = b; v.exp = e; v.lat = lat;
        vecs.push_back(v);
    endtask

    task automatic drive_accept(input logic [2:0] f3, input logic w,
                                input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        in_valid = 1'b1; funct3 = f3; word = w; op_a = a; op_b = b;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int edges);
        edges = 0;
        do begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end while (!out_valid && edges < 200);
    endtask

    task automatic run_vec(input vec_t v);
        int          edges;
        logic [63:0] exp;
        logic [7:0]  oh;
        check({v.name, "/in_ready"}, 64'(in_ready), 64'd1);
        drive_accept(v.f3, v.w, v.a, v.b);
        sb_q.push_back(v.exp);
        oh = 8'h80 >> v.f3;
        check({v.name, "/debug"}, 64'(debug_inst), 64'(oh));
        check({v.name, "/busy"}, 64'(busy), 64'd1);
        wait_valid(edges);
        check({v.name, "/latency"}, 64'(edges), 64'(v.lat));
        exp = sb_q.pop_front();
        check({v.name, "/result"}, result, exp);
        @(posedge clk);
        @(negedge clk);
        check({v.name, "/post_valid"}, 64'(out_valid), 64'd0);
        check({v.name, "/post_idle"}, 64'({in_ready, debug_inst}), 64'h100);
    endtask

    initial begin
        int   edges;
        int   seen;
        vec_t v;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; word = 1'b0; out_ready = 1'b1;
        funct3 = 3'b000; op_a = 64'd0; op_b = 64'd0;

        add("MULH",      MD_MULH,   1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, LAT_MUL);
        add("MUL",       MD_MUL,    1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, LAT_MUL);
        add("MULHU",     MD_MULHU,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, LAT_MUL);
        add("MULHSU",    MD_MULHSU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, LAT_MUL);
        add("DIV_ovf",   MD_DIV,    1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1);
        add("REM_ovf",   MD_REM,    1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
        add("DIVU_z",    MD_DIVU,   1'b0, 64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        add("REMU_z",    MD_REMU,   1'b0, 64'd7, 64'd0, 64'd7, 1);
        add("DIVW",      MD_DIV,    1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33);
        add("REMW",      MD_REM,    1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33);
        add("DIV_neg",   MD_DIV,    1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 65);
        add("REM_neg",   MD_REM,    1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 65);
        add("DIVU",      MD_DIVU,   1'b0, 64'd100, 64'd7, 64'd14, 65);
        add("MULW",      MD_MUL,    1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, LAT_MULW);
        add("DIVUW",     MD_DIVU,   1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 33);
        add("MULHW_ill", MD_MULH,   1'b1, 64'd5, 64'd6, 64'd0, 1);
        add("DIVW_ovf",  MD_DIV,    1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1);
        add("REMUW_z",   MD_REMU,   1'b1, 64'h0000_0001_8000_0005, 64'h0000_0001_0000_0000, 64'hFFFF_FFFF_8000_0005, 1);

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset/out_valid", 64'(out_valid), 64'd0);
        check("reset/in_ready", 64'(in_ready), 64'd1);
        check("reset/busy", 64'(busy), 64'd0);
        check("reset/result", result, 64'd0);
        check("reset/debug", 64'(debug_inst), 64'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // REMU with a stalled consumer: result must hold
        out_ready = 1'b0;
        drive_accept(MD_REMU, 1'b0, 64'd100, 64'd7);
        sb_q.push_back(64'd2);
        wait_valid(edges);
        check("hold/latency", 64'(edges), 64'd65);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold/valid", 64'(out_valid), 64'd1);
            check("hold/result", result, sb_q[0]);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("hold/result_final", result, sb_q.pop_front());
        check("hold/released", 64'(out_valid), 64'd0);

        // flush in CALC cycle 10 kills the op
        drive_accept(MD_DIVU, 1'b0, 64'd1000, 64'd3);
        repeat (9) @(negedge clk);
        check("flush/busy_before", 64'(busy), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush/idle", 64'({busy, in_ready, out_valid}), 64'b010);
        check("flush/debug", 64'(debug_inst), 64'd0);
        seen = 0;
        for (int k = 0; k < 70; k++) begin
            @(negedge clk);
            if (out_valid || busy) seen++;
        end
        check("flush/quiet", 64'(seen), 64'd0);

        // flush together with in_valid drops the request
        @(negedge clk);
        in_valid = 1'b1; flush = 1'b1; funct3 = MD_DIVU; op_a = 64'd9; op_b = 64'd0;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        check("flush_req/dropped", 64'({busy, out_valid}), 64'd0);

        v.name = "after_flush"; v.f3 = MD_DIVU; v.w = 1'b0;
        v.a = 64'd1000; v.b = 64'd3; v.exp = 64'd333; v.lat = 65;
        run_vec(v);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
